// File: rtl/block_pkg.sv
// Shared types and default sizing for the block accumulator.
package block_pkg;

   localparam int unsigned DEF_LOGDEPTH = 6;
   localparam int unsigned DEF_WIDTH    = 32;
   localparam int unsigned DEF_TIMEOUT  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } acc_state_t;

endpackage

// File: rtl/block_accumulator.sv
// Reduces one block of upstream words to sum, max and count, abandoning the
// block if the upstream goes quiet for TIMEOUT cycles.
module block_accumulator
   import block_pkg::*;
#(
   parameter int unsigned LOGDEPTH = DEF_LOGDEPTH,
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      EN_blockRead,
   input  logic                      VALID_memVal,
   input  logic [WIDTH-1:0]          memVal_data,
   output logic                      sum_valid,
   input  logic                      sum_ready,
   output logic [WIDTH+LOGDEPTH-1:0] sum_data,
   output logic [WIDTH-1:0]          sum_max,
   output logic [LOGDEPTH:0]         sum_count,
   output logic                      sum_err
);

   localparam int unsigned ACCW = WIDTH + LOGDEPTH;
   localparam int unsigned TW   = $clog2(TIMEOUT + 1);
   localparam logic [LOGDEPTH:0] LAST_CNT = {1'b0, {LOGDEPTH{1'b1}}};
   localparam logic [LOGDEPTH:0] ONE_CNT  = {{LOGDEPTH{1'b0}}, 1'b1};
   localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]     ONE_TMO  = TW'(1);

   acc_state_t          state_q;
   logic                busy_q;
   logic                en_q;
   logic                valid_q;
   logic [ACCW-1:0]     acc_q;
   logic [WIDTH-1:0]    max_q;
   logic [LOGDEPTH:0]   count_q;
   logic                err_q;
   logic [TW-1:0]       tmo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
         valid_q <= 1'b0;
         acc_q   <= '0;
         max_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= REQ;
                  busy_q  <= 1'b1;
                  en_q    <= 1'b1;
                  acc_q   <= '0;
                  max_q   <= '0;
                  count_q <= '0;
                  err_q   <= 1'b0;
                  tmo_q   <= '0;
               end
            end
            REQ: begin
               state_q <= ACCUM;
               en_q    <= 1'b0;
            end
            ACCUM: begin
               // A word and a timeout can never coincide: a valid word clears the idle count.
               if (VALID_memVal) begin
                  acc_q   <= acc_q + ACCW'(memVal_data);
                  count_q <= count_q + ONE_CNT;
                  tmo_q   <= '0;
                  if (memVal_data > max_q) max_q <= memVal_data;
                  if (count_q == LAST_CNT) begin
                     state_q <= DONE;
                     valid_q <= 1'b1;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + ONE_TMO;
               end
            end
            DONE: begin
               if (sum_ready) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               en_q    <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign EN_blockRead = en_q;
   assign sum_valid    = valid_q;
   assign sum_data     = acc_q;
   assign sum_max      = max_q;
   assign sum_count    = count_q;
   assign sum_err      = err_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Randomised and directed block reductions against a queue-based model,
// with a scoreboard monitor checking each presented result.
module tb_block_accumulator;

   localparam int unsigned LD   = 6;
   localparam int unsigned W    = 32;
   localparam int unsigned TMO  = 16;
   localparam int unsigned NBLK = 1 << LD;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            busy;
   logic            EN_blockRead;
   logic            VALID_memVal;
   logic [W-1:0]    memVal_data;
   logic            sum_valid;
   logic            sum_ready;
   logic [W+LD-1:0] sum_data;
   logic [W-1:0]    sum_max;
   logic [LD:0]     sum_count;
   logic            sum_err;

   block_accumulator #(.LOGDEPTH(LD), .WIDTH(W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
      .EN_blockRead(EN_blockRead), .VALID_memVal(VALID_memVal),
      .memVal_data(memVal_data), .sum_valid(sum_valid), .sum_ready(sum_ready),
      .sum_data(sum_data), .sum_max(sum_max), .sum_count(sum_count),
      .sum_err(sum_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] sum;
      logic [63:0] max;
      logic [63:0] cnt;
      logic        err;
   } res_t;

   res_t sb[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops an expectation when a result appears, then checks it stays put.
   logic        in_done = 1'b0;
   logic [63:0] cap_sum, cap_max, cap_cnt;
   logic        cap_err;
   always @(negedge clk) begin
      if (!rst_n) begin
         in_done = 1'b0;
      end else if (sum_valid && !in_done) begin
         in_done = 1'b1;
         cap_sum = 64'(sum_data);
         cap_max = 64'(sum_max);
         cap_cnt = 64'(sum_count);
         cap_err = sum_err;
         if (sb.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
         end else begin
            res_t e;
            e = sb.pop_front();
            check("sum_data", 64'(sum_data), e.sum);
            check("sum_max", 64'(sum_max), e.max);
            check("sum_count", 64'(sum_count), e.cnt);
            check("sum_err", 64'(sum_err), 64'(e.err));
            check("busy_in_done", 64'(busy), 64'd1);
         end
      end else if (sum_valid && in_done) begin
         check("done_stable", {26'(sum_data), 32'(sum_max), 5'(sum_count), sum_err},
               {26'(cap_sum), 32'(cap_max), 5'(cap_cnt), cap_err});
         check("no_en_in_done", 64'(EN_blockRead), 64'd0);
      end else if (!sum_valid && in_done) begin
         in_done = 1'b0;
         check("idle_busy", 64'(busy), 64'd0);
         check("idle_hold_sum", 64'(sum_data), cap_sum);
         check("idle_hold_cnt", 64'(sum_count), cap_cnt);
      end
   end

   // Reference: accept words until 2**LD are taken or an idle stretch reaches TMO.
   task automatic model(input int unsigned words[$], input int unsigned gaps[$],
                        output res_t r, output int unsigned nacc, output bit tmo);
      longint unsigned s = 0;
      int unsigned mx = 0;
      nacc = 0;
      tmo  = 0;
      foreach (words[i]) begin
         if (gaps[i] >= TMO) begin
            tmo = 1;
            break;
         end
         s += words[i];
         if (words[i] > mx) mx = words[i];
         nacc++;
         if (nacc == NBLK) break;
      end
      if (nacc < NBLK) tmo = 1;
      r.sum = 64'(s);
      r.max = 64'(mx);
      r.cnt = 64'(nacc);
      r.err = tmo;
   endtask

   task automatic start_block();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("en_pulse", 64'(EN_blockRead), 64'd1);
      check("busy_req", 64'(busy), 64'd1);
      tick();
      check("en_drop", 64'(EN_blockRead), 64'd0);
   endtask

   task automatic run_block(input int unsigned words[$], input int unsigned gaps[$],
                            input int unsigned rdelay, input bit poke_start);
      res_t r;
      int unsigned nacc;
      bit tmo;
      int unsigned k;
      model(words, gaps, r, nacc, tmo);
      sb.push_back(r);
      start_block();
      for (int unsigned i = 0; i < nacc; i++) begin
         VALID_memVal = 1'b0;
         for (int unsigned g = 0; g < gaps[i]; g++) tick();
         VALID_memVal = 1'b1;
         memVal_data  = words[i];
         tick();
      end
      VALID_memVal = 1'b0;
      memVal_data  = $urandom;
      if (tmo) for (int unsigned g = 0; g < TMO; g++) tick();
      k = 0;
      while (!sum_valid && k < 40) begin
         tick();
         k++;
      end
      if (!sum_valid) check("sum_valid_timeout", 64'd0, 64'd1);
      for (int unsigned d = 0; d < rdelay; d++) begin
         start        = poke_start;
         VALID_memVal = 1'($urandom);
         tick();
      end
      VALID_memVal = 1'b0;
      sum_ready    = 1'b1;
      start        = poke_start;
      tick();
      sum_ready = 1'b0;
      start     = 1'b0;
      check("idle_after_ready", 64'(busy), 64'd0);
      tick();
      check("start_ignored_on_handshake", 64'(busy), 64'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_en", 64'(EN_blockRead), 64'd0);
      check("rst_valid", 64'(sum_valid), 64'd0);
      check("rst_outputs", {26'(sum_data), 32'(sum_max), 5'(sum_count), sum_err}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned w[$];
      int unsigned g[$];
      rst_n = 1'b0;
      start = 1'b0;
      VALID_memVal = 1'b0;
      memVal_data  = '0;
      sum_ready    = 1'b0;
      #1;
      check_reset_outputs();
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 64 ones
      w = {}; g = {};
      for (int unsigned i = 0; i < NBLK; i++) begin w.push_back(1); g.push_back(0); end
      run_block(w, g, 0, 1'b0);

      // 0..63 with two idle cycles between words
      w = {}; g = {};
      for (int unsigned i = 0; i < NBLK; i++) begin w.push_back(i); g.push_back(2); end
      run_block(w, g, 1, 1'b0);

      // all-ones words: largest possible sum
      w = {}; g = {};
      for (int unsigned i = 0; i < NBLK; i++) begin w.push_back(32'hFFFF_FFFF); g.push_back(0); end
      run_block(w, g, 0, 1'b0);

      // ten fives then silence: timeout with partial result
      w = {}; g = {};
      for (int unsigned i = 0; i < 10; i++) begin w.push_back(5); g.push_back(0); end
      run_block(w, g, 0, 1'b0);

      // gap of TMO-1 survives, consumer stalls five cycles while start is pulsed
      w = {}; g = {};
      for (int unsigned i = 0; i < NBLK; i++) begin w.push_back(i * 3 + 7); g.push_back(i == 5 ? TMO - 1 : 0); end
      run_block(w, g, 5, 1'b1);

      // reset after 20 words, then a fresh block
      start_block();
      for (int unsigned i = 0; i < 20; i++) begin
         VALID_memVal = 1'b1;
         memVal_data  = 32'd9;
         tick();
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      VALID_memVal = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", 64'(busy), 64'd0);
      w = {}; g = {};
      for (int unsigned i = 0; i < NBLK; i++) begin w.push_back(1); g.push_back(0); end
      run_block(w, g, 0, 1'b0);

      // random blocks
      for (int b = 0; b < 24; b++) begin
         int unsigned n;
         w = {}; g = {};
         n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NBLK) : NBLK;
         for (int unsigned i = 0; i < n; i++) begin
            case ($urandom_range(0, 5))
               0:       w.push_back(0);
               1:       w.push_back(32'hFFFF_FFFF);
               default: w.push_back($urandom);
            endcase
            if ($urandom_range(0, 40) == 0)
               g.push_back($urandom_range(TMO - 1, TMO + 3));
            else
               g.push_back($urandom_range(0, 3));
         end
         run_block(w, g, $urandom_range(0, 4), 1'($urandom));
      end

      repeat (3) tick();
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/block_accumulator.md
BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

Interface
REQ-001 SHALL have parameter LOGDEPTH, default 6, log2 of the number of words in one memory block.
REQ-002 SHALL have parameter WIDTH, default 32, the data word width.
REQ-003 SHALL have parameter TIMEOUT, default 16, the number of idle cycles before a read is abandoned.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request one block reduction; honoured only in IDLE.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port EN_blockRead, output, 1 bit: one-cycle pulse to the upstream multiplier requesting a block read.
REQ-009 SHALL have port VALID_memVal, input, 1 bit: upstream word-valid strobe.
REQ-010 SHALL have port memVal_data, input, WIDTH bits: upstream word.
REQ-011 SHALL have port sum_valid, output, 1 bit: result available.
REQ-012 SHALL have port sum_ready, input, 1 bit: result consumer ready.
REQ-013 SHALL have port sum_data, output, WIDTH+LOGDEPTH bits: unsigned sum of the words accepted.
REQ-014 SHALL have port sum_max, output, WIDTH bits: largest word accepted.
REQ-015 SHALL have port sum_count, output, LOGDEPTH+1 bits: number of words accepted.
REQ-016 SHALL have port sum_err, output, 1 bit: the block ended by timeout.

Function
REQ-017 SHALL implement a state machine with states IDLE, REQ, ACCUM and DONE.
REQ-018 SHALL go from IDLE to REQ when start=1, clearing the accumulator, max, count, error flag and timeout counter on that edge.
REQ-019 SHALL assert EN_blockRead only while in REQ, which lasts exactly 1 cycle, then go to ACCUM.
REQ-020 SHALL, in ACCUM, on each cycle with VALID_memVal=1, add the zero-extended memVal_data to the accumulator, increment the count, update the max (replace on strictly greater) and clear the timeout counter.
REQ-021 SHALL go to DONE on the edge that accepts word number 2**LOGDEPTH, so sum_valid rises 1 cycle after the last word.
REQ-022 SHALL, in ACCUM, increment the timeout counter on each cycle with VALID_memVal=0; on reaching TIMEOUT it SHALL go to DONE with sum_err=1 and the partial sum and count.
REQ-023 SHALL ignore VALID_memVal in IDLE, REQ and DONE (no state change).
REQ-024 SHALL, in DONE, hold sum_valid=1 with sum_data, sum_max, sum_count and sum_err stable until sum_ready=1, then go to IDLE on that edge.
REQ-025 SHALL ignore start in REQ, ACCUM and DONE, including on the DONE->IDLE handshake edge.
REQ-026 SHALL drive sum_data, sum_max, sum_count and sum_err from registers; they hold their last values in IDLE.
REQ-027 SHALL never overflow the accumulator: the maximum sum (2**LOGDEPTH)*(2**WIDTH-1) fits in WIDTH+LOGDEPTH bits.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE and drive busy=0, EN_blockRead=0, sum_valid=0, sum_data=0, sum_max=0, sum_count=0 and sum_err=0, with all internal counters at 0.
REQ-029 SHALL abandon any block in progress on reset in any state and require a new start afterwards.

Structure
REQ-030 SHALL define the state enum acc_state_t and the default constants for LOGDEPTH, WIDTH and TIMEOUT in the shared package block_pkg.
REQ-031 SHALL be implemented as a single module with no sub-modules; the timeout counter SHALL be implemented inline.

Verification
REQ-032 SHALL cover: start, then 64 words of value 1 -> sum_data=64, count=64, max=1, err=0.
REQ-033 SHALL cover: 64 words 0..63 with 2-cycle gaps between words -> sum_data=2016, max=63, err=0.
REQ-034 SHALL cover: 64 words of 0xFFFFFFFF -> sum_data=0x3FFFFFFFC0, max=0xFFFFFFFF.
REQ-035 SHALL cover: 10 words of 5, then 16 cycles with VALID_memVal=0 -> DONE with sum=50, count=10, err=1.
REQ-036 SHALL cover: sum_ready held low 5 cycles in DONE with start pulsed -> outputs stable, no new EN_blockRead, return to IDLE on sum_ready.
REQ-037 SHALL cover: rst_n pulsed low after 20 words -> all outputs 0 at once; the next block of 64 ones gives sum=64.
